microsequencer: RTL and testbench
=================================

Name: microsequencer

Overview:
- Parametrised microprogrammed control unit: a writable microstore plus an explicit microprogram counter (state register) with next-state sequencing logic.
- Each microstore word holds the control-signal vector for its state, plus a sequencing field that selects the next state. Sequencing modes are increment, jump, opcode dispatch, conditional branch, call/return and wait.
- Sits between the instruction decoder (dispatch address, condition flags) and the datapath control inputs.

Parameters:
SIG_W, 45, width of control-signal vector per state
STATE_W, 7, width of state/microstore address
DEPTH, 64, number of implemented microstore words (DEPTH <= 2**STATE_W)
NCOND, 4, number of external condition inputs (1..7)
STACK_DEPTH, 2, depth of microsubroutine return stack (>=1)
RESET_VECTOR, 45'h4C000008021, control vector driven while reset is high

Ports:
clk  input  1  clock, all state changes on rising edge
reset  input  1  synchronous, active-high reset
stall  input  1  holds current state; no advance, push or pop
dispatch_addr  input  STATE_W  target state for DISPATCH mode (from decoder)
cond_in  input  NCOND  condition flags (MOC, branch true, ...)
wr_en  input  1  microstore write enable
wr_addr  input  STATE_W  microstore write address
wr_data  input  SIG_W+STATE_W+7  microstore word to write
current_state_signals  output  SIG_W  control vector of active state
active_state  output  STATE_W  current state register value
seq_err  output  3  sticky {bad_addr, stack_underflow, stack_overflow}

Behaviour:
- Word layout, MSB first: {signals[SIG_W], next_addr[STATE_W], mode[3], csel[3], cinv[1]}. The microstore is not cleared by reset.
- Cond: csel=0 gives 1. csel=k (1..NCOND) gives cond_in[k-1]. csel>NCOND gives 0. cond = that value XOR cinv.
- Outputs are combinational from the state register: current_state_signals = mem[state].signals; active_state = state. Read has zero latency.
- While reset is high:
  - current_state_signals = RESET_VECTOR; active_state = 0.
  - On each edge: state<=0, stack pointer<=0, seq_err<=0.
  - Writes still take effect, so the microprogram can be loaded under reset.
- Cycle after reset deasserts: state=0, outputs = mem[0].signals.
- Next state, computed at each rising edge when not reset and not stall:
  - mode 0 INC: state+1
  - mode 1 JUMP: next_addr
  - mode 2 DISPATCH: dispatch_addr
  - mode 3 COND: cond ? next_addr : state+1
  - mode 4 CALL: push state+1, go to next_addr
  - mode 5 RET: pop into state
  - mode 6 WAIT: cond ? state+1 : state (hold)
  - mode 7 FETCH: 0
- Arithmetic: state+1 is computed modulo 2**STATE_W.
- Any computed next state >= DEPTH sets seq_err[2] and loads 0 instead.
- CALL with stack full:
  - sets seq_err[0]; no push; jump still taken.
  - stack contents and pointer are unchanged.
- RET with stack empty: sets seq_err[1]; state<=0.
- Pushed return address is not range-checked until it is popped.
- stall=1: state, stack and seq_err are frozen; outputs are unchanged except when the active word is rewritten.
- Write: mem[wr_addr] <= wr_data at the edge. A wr_addr >= DEPTH is ignored with no error.
  - If wr_addr equals the next state, the new word is visible immediately after that edge.
  - If wr_addr equals the held state (stall), the new signals appear after the edge.
  - The sequencing decision at an edge uses the pre-write word.
- Reset asserted mid-subroutine or mid-wait: the stack is discarded and state=0 on that edge.
- seq_err bits clear only on reset.

Test Plan:
- Load mem[0]=INC, mem[1]=JUMP next_addr=5, mem[5]=FETCH under reset; release reset -> active_state 0,1,5,0,1; current_state_signals matches each word. During reset, signals = 45'h4C000008021.
- mem[2]=WAIT csel=1 (MOC), cond_in[0]=0 for 3 cycles then 1 -> state holds at 2 for 3 cycles, then goes to 3. Repeat with cinv=1 -> inverted behaviour.
- mem[3]=DISPATCH, dispatch_addr=9; mem[9]=COND csel=2, next_addr=20 -> with cond_in[1]=1 state goes 9->20; with cond_in[1]=0 it goes 9->10.
- STACK_DEPTH=2: CALL at 4 and at 21, then a third CALL -> seq_err=3'b001, jump still taken. Two RETs return to 22 then 5; a third RET -> seq_err=3'b011 and state 0.
- JUMP next_addr=70 with DEPTH=64 -> state 0, seq_err[2]=1. stall=1 for 2 cycles at state 7 -> active_state stays 7, no stack change.
- At state 6 with stall=1, write mem[6] with new signals -> outputs change after that edge. Assert reset at a WAIT in a subroutine -> next cycle state 0, seq_err 0, stack empty (a subsequent RET sets underflow).

Source files
------------

// File: rtl/microsequencer.sv
// Microprogrammed control unit: writable microstore plus microprogram counter and return stack.
// Outputs are combinational from the state register (zero latency); i_stall freezes state, stack and errors.
module microsequencer #(
    parameter int                SIG_W        = 45,
    parameter int                STATE_W      = 7,
    parameter int                DEPTH        = 64,
    parameter int                NCOND        = 4,
    parameter int                STACK_DEPTH  = 2,
    parameter logic [SIG_W-1:0]  RESET_VECTOR = 45'h4C000008021
) (
    input  logic                       i_clk,
    input  logic                       i_reset,
    input  logic                       i_stall,
    input  logic [STATE_W-1:0]         i_dispatch_addr,
    input  logic [NCOND-1:0]           i_cond_in,
    input  logic                       i_wr_en,
    input  logic [STATE_W-1:0]         i_wr_addr,
    input  logic [SIG_W+STATE_W+6:0]   i_wr_data,
    output logic [SIG_W-1:0]           o_current_state_signals,
    output logic [STATE_W-1:0]         o_active_state,
    output logic [2:0]                 o_seq_err
);

    localparam int WORD_W = SIG_W + STATE_W + 7;
    localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int SP_W   = $clog2(STACK_DEPTH + 1);
    localparam int STK_N  = 1 << SP_W;
    localparam logic [STATE_W:0] DEPTH_L = (STATE_W + 1)'(DEPTH);
    localparam logic [SP_W-1:0]  SP_FULL = SP_W'(STACK_DEPTH);

    typedef enum logic [2:0] {
        MODE_INC      = 3'd0,
        MODE_JUMP     = 3'd1,
        MODE_DISPATCH = 3'd2,
        MODE_COND     = 3'd3,
        MODE_CALL     = 3'd4,
        MODE_RET      = 3'd5,
        MODE_WAIT     = 3'd6,
        MODE_FETCH    = 3'd7
    } mode_e;

    logic [WORD_W-1:0]  r_mem   [0:DEPTH-1];
    logic [STATE_W-1:0] r_stack [0:STK_N-1];
    logic [STATE_W-1:0] r_state;
    logic [SP_W-1:0]    r_sp;
    logic [2:0]         r_seq_err;

    logic [WORD_W-1:0]  w_word;
    logic [SIG_W-1:0]   w_sig;
    logic [STATE_W-1:0] w_next_addr;
    mode_e              w_mode;
    logic [2:0]         w_csel;
    logic               w_cinv;
    logic [7:0]         w_cond_vec;
    logic               w_cond;
    logic [STATE_W-1:0] w_inc;
    logic [STATE_W-1:0] w_target;
    logic [STATE_W-1:0] w_next_state;
    logic               w_push;
    logic               w_pop;
    logic               w_ovf;
    logic               w_udf;
    logic               w_bad;

    // r_state is always < DEPTH, so the truncated index never aliases.
    assign w_word      = r_mem[r_state[MEM_AW-1:0]];
    assign w_sig       = w_word[WORD_W-1 -: SIG_W];
    assign w_next_addr = w_word[7 +: STATE_W];
    assign w_mode      = mode_e'(w_word[6:4]);
    assign w_csel      = w_word[3:1];
    assign w_cinv      = w_word[0];

    // Bit 0 is the constant-true select; selects above NCOND read zero.
    always_comb begin
        w_cond_vec            = '0;
        w_cond_vec[NCOND:0]   = {i_cond_in, 1'b1};
    end
    assign w_cond = w_cond_vec[w_csel] ^ w_cinv;

    assign w_inc = r_state + 1'b1;

    always_comb begin
        w_target = w_inc;
        w_push   = 1'b0;
        w_pop    = 1'b0;
        w_ovf    = 1'b0;
        w_udf    = 1'b0;
        case (w_mode)
            MODE_INC:      w_target = w_inc;
            MODE_JUMP:     w_target = w_next_addr;
            MODE_DISPATCH: w_target = i_dispatch_addr;
            MODE_COND:     w_target = w_cond ? w_next_addr : w_inc;
            MODE_CALL: begin
                w_target = w_next_addr;
                if (r_sp == SP_FULL) begin
                    w_ovf = 1'b1;
                end else begin
                    w_push = 1'b1;
                end
            end
            MODE_RET: begin
                if (r_sp == '0) begin
                    w_udf    = 1'b1;
                    w_target = '0;
                end else begin
                    w_pop    = 1'b1;
                    w_target = r_stack[r_sp - 1'b1];
                end
            end
            MODE_WAIT:     w_target = w_cond ? w_inc : r_state;
            MODE_FETCH:    w_target = '0;
        endcase
    end

    assign w_bad        = ({1'b0, w_target} >= DEPTH_L);
    assign w_next_state = w_bad ? '0 : w_target;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state   <= '0;
            r_sp      <= '0;
            r_seq_err <= '0;
        end else if (!i_stall) begin
            r_state   <= w_next_state;
            r_seq_err <= r_seq_err | {w_bad, w_udf, w_ovf};
            if (w_push) begin
                r_sp <= r_sp + 1'b1;
            end else if (w_pop) begin
                r_sp <= r_sp - 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset && !i_stall && w_push) begin
            r_stack[r_sp] <= w_inc;
        end
    end

    // Microstore is not reset so it can be loaded while reset is held.
    always_ff @(posedge i_clk) begin
        if (i_wr_en && ({1'b0, i_wr_addr} < DEPTH_L)) begin
            r_mem[i_wr_addr[MEM_AW-1:0]] <= i_wr_data;
        end
    end

    assign o_current_state_signals = i_reset ? RESET_VECTOR : w_sig;
    assign o_active_state          = i_reset ? '0 : r_state;
    assign o_seq_err               = r_seq_err;

endmodule

// File: tb/tb_microsequencer.sv
// Directed bench for microsequencer: vector table per microprogram plus hand sequences for write/stall/reset corners.
module tb_microsequencer;

    localparam logic [44:0] RST_VEC = 45'h4C000008021;
    localparam logic [2:0] INC = 3'd0, JUMP = 3'd1, DISP = 3'd2, CONDM = 3'd3,
                           CALL = 3'd4, RET = 3'd5, WAITM = 3'd6, FETCH = 3'd7;

    logic        clk = 1'b0;
    logic        i_reset = 1'b1;
    logic        i_stall = 1'b0;
    logic [6:0]  i_dispatch_addr = '0;
    logic [3:0]  i_cond_in = '0;
    logic        i_wr_en = 1'b0;
    logic [6:0]  i_wr_addr = '0;
    logic [58:0] i_wr_data = '0;
    logic [44:0] o_sig;
    logic [6:0]  o_state;
    logic [2:0]  o_err;

    int nchecks = 0;
    int nerr    = 0;

    microsequencer dut (
        .i_clk                   (clk),
        .i_reset                 (i_reset),
        .i_stall                 (i_stall),
        .i_dispatch_addr         (i_dispatch_addr),
        .i_cond_in               (i_cond_in),
        .i_wr_en                 (i_wr_en),
        .i_wr_addr               (i_wr_addr),
        .i_wr_data               (i_wr_data),
        .o_current_state_signals (o_sig),
        .o_active_state          (o_state),
        .o_seq_err               (o_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       stall;
        logic [3:0] cond;
        logic [6:0] disp;
        logic [6:0] exp_state;
        logic [2:0] exp_err;
    } vec_t;

    vec_t tbl[$];

    function automatic logic [44:0] sigv(input logic [6:0] a);
        return {8'hA5, 30'h1234567, a};
    endfunction

    function automatic logic [58:0] mk(input logic [44:0] s, input logic [6:0] na,
                                       input logic [2:0] m, input logic [2:0] cs, input logic ci);
        return {s, na, m, cs, ci};
    endfunction

    task automatic add(input logic st, input logic [3:0] c, input logic [6:0] d,
                       input logic [6:0] es, input logic [2:0] ee);
        vec_t v;
        v.stall = st; v.cond = c; v.disp = d; v.exp_state = es; v.exp_err = ee;
        tbl.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nchecks++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic put(input logic [6:0] a, input logic [58:0] w);
        @(negedge clk);
        i_wr_en = 1'b1; i_wr_addr = a; i_wr_data = w;
        @(posedge clk);
        #1 i_wr_en = 1'b0;
    endtask

    task automatic start_load();
        @(negedge clk);
        i_reset = 1'b1; i_stall = 1'b0; i_cond_in = '0; i_dispatch_addr = '0;
    endtask

    task automatic run_rows(input int lo, input int hi, input string nm);
        @(negedge clk);
        i_reset = 1'b0;
        for (int i = lo; i <= hi; i++) begin
            if (i != lo) @(negedge clk);
            i_stall = tbl[i].stall; i_cond_in = tbl[i].cond; i_dispatch_addr = tbl[i].disp;
            #1;
            chk($sformatf("%s row%0d state", nm, i), 64'(o_state), 64'(tbl[i].exp_state));
            chk($sformatf("%s row%0d sig", nm, i), 64'(o_sig), 64'(sigv(tbl[i].exp_state)));
            chk($sformatf("%s row%0d err", nm, i), 64'(o_err), 64'(tbl[i].exp_err));
        end
        i_stall = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int p1, p2, p3, p4, p5, p6;
        // P1: INC / JUMP / FETCH loop
        add(0, 4'h0, 7'd0, 7'd0, 3'b000);
        add(0, 4'h0, 7'd0, 7'd1, 3'b000);
        add(0, 4'h0, 7'd0, 7'd5, 3'b000);
        add(0, 4'h0, 7'd0, 7'd0, 3'b000);
        add(0, 4'h0, 7'd0, 7'd1, 3'b000);
        p2 = tbl.size();
        // P2: WAIT on cond_in[0], then inverted WAIT
        add(0, 4'h0, 7'd0, 7'd0, 3'b000);
        add(0, 4'h0, 7'd0, 7'd2, 3'b000);
        add(0, 4'h0, 7'd0, 7'd2, 3'b000);
        add(0, 4'h0, 7'd0, 7'd2, 3'b000);
        add(0, 4'h1, 7'd0, 7'd2, 3'b000);
        add(0, 4'h1, 7'd0, 7'd3, 3'b000);
        add(0, 4'h1, 7'd0, 7'd3, 3'b000);
        add(0, 4'h0, 7'd0, 7'd3, 3'b000);
        add(0, 4'h0, 7'd0, 7'd4, 3'b000);
        add(0, 4'h0, 7'd0, 7'd0, 3'b000);
        p3 = tbl.size();
        // P3: DISPATCH then COND on cond_in[1], both outcomes
        add(0, 4'h0, 7'd0, 7'd0,  3'b000);
        add(0, 4'h0, 7'd9, 7'd3,  3'b000);
        add(0, 4'h2, 7'd0, 7'd9,  3'b000);
        add(0, 4'h0, 7'd0, 7'd20, 3'b000);
        add(0, 4'h0, 7'd0, 7'd0,  3'b000);
        add(0, 4'h0, 7'd9, 7'd3,  3'b000);
        add(0, 4'hD, 7'd0, 7'd9,  3'b000);
        add(0, 4'h0, 7'd0, 7'd10, 3'b000);
        add(0, 4'h0, 7'd0, 7'd0,  3'b000);
        p4 = tbl.size();
        // P4: CALL, CALL, overflowing CALL, RET, RET, underflowing RET
        add(0, 4'h0, 7'd0, 7'd0,  3'b000);
        add(0, 4'h0, 7'd0, 7'd4,  3'b000);
        add(0, 4'h0, 7'd0, 7'd21, 3'b000);
        add(0, 4'h0, 7'd0, 7'd30, 3'b000);
        add(0, 4'h0, 7'd0, 7'd40, 3'b001);
        add(0, 4'h0, 7'd0, 7'd22, 3'b001);
        add(0, 4'h0, 7'd0, 7'd5,  3'b001);
        add(0, 4'h0, 7'd0, 7'd0,  3'b011);
        add(0, 4'h0, 7'd0, 7'd4,  3'b011);
        p5 = tbl.size();
        // P5: stalled CALL must not push; returns then out-of-range JUMP
        add(0, 4'h0, 7'd0, 7'd0,  3'b000);
        add(1, 4'h0, 7'd0, 7'd7,  3'b000);
        add(1, 4'h0, 7'd0, 7'd7,  3'b000);
        add(0, 4'h0, 7'd0, 7'd7,  3'b000);
        add(0, 4'h0, 7'd0, 7'd50, 3'b000);
        add(0, 4'h0, 7'd0, 7'd8,  3'b000);
        add(0, 4'h0, 7'd0, 7'd1,  3'b000);
        add(0, 4'h0, 7'd0, 7'd0,  3'b100);
        add(0, 4'h0, 7'd0, 7'd7,  3'b100);
        p6 = tbl.size();
        p1 = 0;

        start_load();
        put(7'd0, mk(sigv(0), 7'd0, INC,   3'd0, 1'b0));
        put(7'd1, mk(sigv(1), 7'd5, JUMP,  3'd0, 1'b0));
        put(7'd5, mk(sigv(5), 7'd0, FETCH, 3'd0, 1'b0));
        @(negedge clk); #1;
        chk("reset sig", 64'(o_sig), 64'(RST_VEC));
        chk("reset state", 64'(o_state), 64'd0);
        chk("reset err", 64'(o_err), 64'd0);
        run_rows(p1, p2 - 1, "inc_jump");

        start_load();
        put(7'd0, mk(sigv(0), 7'd2, JUMP,  3'd0, 1'b0));
        put(7'd2, mk(sigv(2), 7'd0, WAITM, 3'd1, 1'b0));
        put(7'd3, mk(sigv(3), 7'd0, WAITM, 3'd1, 1'b1));
        put(7'd4, mk(sigv(4), 7'd0, FETCH, 3'd0, 1'b0));
        run_rows(p2, p3 - 1, "wait");

        start_load();
        put(7'd0,  mk(sigv(0),  7'd3,  JUMP,  3'd0, 1'b0));
        put(7'd3,  mk(sigv(3),  7'd0,  DISP,  3'd0, 1'b0));
        put(7'd9,  mk(sigv(9),  7'd20, CONDM, 3'd2, 1'b0));
        put(7'd10, mk(sigv(10), 7'd0,  FETCH, 3'd0, 1'b0));
        put(7'd20, mk(sigv(20), 7'd0,  FETCH, 3'd0, 1'b0));
        run_rows(p3, p4 - 1, "dispatch_cond");

        start_load();
        put(7'd0,  mk(sigv(0),  7'd4,  JUMP, 3'd0, 1'b0));
        put(7'd4,  mk(sigv(4),  7'd21, CALL, 3'd0, 1'b0));
        put(7'd21, mk(sigv(21), 7'd30, CALL, 3'd0, 1'b0));
        put(7'd30, mk(sigv(30), 7'd40, CALL, 3'd0, 1'b0));
        put(7'd40, mk(sigv(40), 7'd0,  RET,  3'd0, 1'b0));
        put(7'd22, mk(sigv(22), 7'd0,  RET,  3'd0, 1'b0));
        put(7'd5,  mk(sigv(5),  7'd0,  RET,  3'd0, 1'b0));
        run_rows(p4, p5 - 1, "stack");

        start_load();
        put(7'd0,  mk(sigv(0),  7'd7,  CALL, 3'd0, 1'b0));
        put(7'd7,  mk(sigv(7),  7'd50, CALL, 3'd0, 1'b0));
        put(7'd50, mk(sigv(50), 7'd0,  RET,  3'd0, 1'b0));
        put(7'd8,  mk(sigv(8),  7'd0,  RET,  3'd0, 1'b0));
        put(7'd1,  mk(sigv(1),  7'd70, JUMP, 3'd0, 1'b0));
        run_rows(p5, p6 - 1, "stall_bad");

        // Writes: stalled active word, next-state word, pre-write decision, out-of-range address
        start_load();
        put(7'd0,  mk(sigv(0),  7'd6, JUMP,  3'd0, 1'b0));
        put(7'd6,  mk(sigv(6),  7'd0, FETCH, 3'd0, 1'b0));
        put(7'd12, mk(sigv(12), 7'd0, FETCH, 3'd0, 1'b0));
        put(7'd15, mk(sigv(15), 7'd0, FETCH, 3'd0, 1'b0));
        @(negedge clk); i_reset = 1'b0; #1;
        chk("wr start state", 64'(o_state), 64'd0);
        @(negedge clk); #1;
        chk("wr at6 sig", 64'(o_sig), 64'(sigv(6)));
        i_stall = 1'b1; i_wr_en = 1'b1; i_wr_addr = 7'd6;
        i_wr_data = mk(45'h0BEEF_0000B, 7'd12, JUMP, 3'd0, 1'b0);
        @(negedge clk); #1;
        chk("stall write state", 64'(o_state), 64'd6);
        chk("stall write sig", 64'(o_sig), 64'(45'h0BEEF_0000B));
        i_stall = 1'b0; i_wr_en = 1'b0;
        @(negedge clk); #1;
        chk("rewritten word jump", 64'(o_state), 64'd12);
        i_wr_en = 1'b1; i_wr_addr = 7'd0; i_wr_data = mk(45'h0CCCC_0000C, 7'd15, JUMP, 3'd0, 1'b0);
        @(negedge clk); #1;
        chk("next-state write state", 64'(o_state), 64'd0);
        chk("next-state write sig", 64'(o_sig), 64'(45'h0CCCC_0000C));
        i_wr_data = mk(45'h0DDDD_0000D, 7'd0, FETCH, 3'd0, 1'b0);
        @(negedge clk); #1;
        chk("pre-write decision", 64'(o_state), 64'd15);
        i_wr_addr = 7'd64; i_wr_data = mk(45'h0EEEE_0000E, 7'd0, FETCH, 3'd0, 1'b0);
        @(negedge clk); #1;
        chk("oob write state", 64'(o_state), 64'd0);
        chk("oob write ignored", 64'(o_sig), 64'(45'h0DDDD_0000D));
        chk("write path err", 64'(o_err), 64'd0);
        i_wr_en = 1'b0;

        // Reset inside a subroutine while waiting: stack must be discarded
        start_load();
        put(7'd0,  mk(sigv(0),  7'd10, CALL,  3'd0, 1'b0));
        put(7'd10, mk(sigv(10), 7'd0,  WAITM, 3'd1, 1'b0));
        @(negedge clk); i_reset = 1'b0; #1;
        chk("sub start", 64'(o_state), 64'd0);
        @(negedge clk); #1;
        chk("sub enter", 64'(o_state), 64'd10);
        @(negedge clk); #1;
        chk("sub wait hold", 64'(o_state), 64'd10);
        i_reset = 1'b1; #1;
        chk("mid reset sig", 64'(o_sig), 64'(RST_VEC));
        chk("mid reset state", 64'(o_state), 64'd0);
        put(7'd0, mk(sigv(0), 7'd0, RET, 3'd0, 1'b0));
        @(negedge clk); i_reset = 1'b0; #1;
        chk("post reset state", 64'(o_state), 64'd0);
        chk("post reset err", 64'(o_err), 64'd0);
        @(negedge clk); #1;
        chk("empty stack ret err", 64'(o_err), 64'b010);
        chk("empty stack ret state", 64'(o_state), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
        $finish;
    end

endmodule
